conv_channel_accum: RTL and testbench

Pipelined multi-channel convolution engine for one output pixel. Each accepted beat carries one input channel's KERNEL×KERNEL window and weights. The block forms the window dot-product, accumulates it over CH consecutive beats, adds a per-pixel bias, and applies optional ReLU and saturation. It emits one OUT_W result per CH beats and uses valid/ready handshakes on both sides, so it chains directly between a line buffer and the output writer.

---
 rtl/conv_channel_accum.sv | 188 ++++++++++++++++++
 tb/tb_conv_channel_accum.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_accum.sv
// conv_channel_accum: pipelined multi-channel window dot-product with bias,
// optional ReLU and output saturation. One result per CH accepted beats.
// Stages: S1 products, S2 window sum, S3 channel accumulator, output register.
module conv_channel_accum #(
   parameter int KERNEL = 3,
   parameter int E      = 4,
   parameter int N      = 4,
   parameter int M      = 4,
   parameter int CH     = 4,
   parameter int B_W    = 8,
   parameter int OUT_W  = 8,
   parameter int SIGNED = 0,
   parameter int RELU   = 1,
   localparam int CI_W  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [KERNEL*KERNEL*N-1:0] data2conv,
   input  logic [KERNEL*KERNEL*M-1:0] w,
   input  logic [B_W-1:0]             bias,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           result,
   output logic                       sat,
   output logic [CI_W-1:0]            ch_idx
);

   localparam int TAPS  = KERNEL * KERNEL;
   localparam int P_W   = N + M;
   localparam int G_W   = N + M + E + $clog2(CH);
   localparam int ACC_W = ((G_W > B_W) ? G_W : B_W) + 2;

   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2 ** (OUT_W - 1)));
   localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((2 ** OUT_W) - 1);

   logic adv, accept, first_c, last_c;

   logic [P_W-1:0]          prod_c [TAPS];
   logic                    s1_valid, s1_first, s1_last;
   logic [B_W-1:0]          s1_bias;
   logic [P_W-1:0]          s1_prod [TAPS];

   logic signed [ACC_W-1:0] sum_c;
   logic                    s2_valid, s2_first, s2_last;
   logic [B_W-1:0]          s2_bias;
   logic signed [ACC_W-1:0] s2_sum;

   logic signed [ACC_W-1:0] bias_ext;
   logic                    s3_valid, s3_last;
   logic signed [ACC_W-1:0] acc;

   logic signed [ACC_W-1:0] relu_v;
   logic [OUT_W-1:0]        res_c;
   logic                    sat_c;

   // One advance enable stalls the whole pipe while a result waits downstream.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign accept   = in_valid & adv;
   assign first_c  = (ch_idx == '0);
   assign last_c   = (ch_idx == CI_W'(CH - 1));

   // Channel counter: position of the next accepted beat inside its group.
   // NOTE: clocked state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr)  ch_idx <= '0;
      else if (accept) ch_idx <= last_c ? '0 : ch_idx + 1'b1;
   end

   // Per-tap products, operands extended to full product width first.
   // NOTE: every output of a combinational block is assigned on all paths, so no latch.
   always_comb begin
      for (int i = 0; i < TAPS; i++) begin
         if (SIGNED != 0)
            prod_c[i] = {{M{data2conv[i*N+N-1]}}, data2conv[i*N +: N]} *
                        {{N{w[i*M+M-1]}}, w[i*M +: M]};
         else
            prod_c[i] = {{M{1'b0}}, data2conv[i*N +: N]} * {{N{1'b0}}, w[i*M +: M]};
      end
   end

   // S1 control: valid and group tags; a beat arriving with clr is discarded.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_first <= first_c;
         s1_last  <= last_c;
      end
   end

   // S1 data capture.
   // NOTE: datapath registers and arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_bias <= bias;
         for (int i = 0; i < TAPS; i++) s1_prod[i] <= prod_c[i];
      end
   end

   // Full-precision window sum, products sign/zero-extended to ACC_W.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < TAPS; i++)
         sum_c = sum_c + {{(ACC_W-P_W){(SIGNED != 0) & s1_prod[i][P_W-1]}}, s1_prod[i]};
   end

   // S2 control.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s2_valid <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         s2_first <= s1_first;
         s2_last  <= s1_last;
      end
   end

   // S2 data capture.
   always_ff @(posedge clk) begin
      if (adv && s1_valid) begin
         s2_bias <= s1_bias;
         s2_sum  <= sum_c;
      end
   end

   assign bias_ext = {{(ACC_W-B_W){(SIGNED != 0) & s2_bias[B_W-1]}}, s2_bias};

   // S3 accumulator: first beat of a group restarts from the bias.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         s3_valid <= 1'b0;
         s3_last  <= 1'b0;
         acc      <= '0;
      end else if (adv) begin
         s3_valid <= s2_valid;
         s3_last  <= s2_valid & s2_last;
         if (s2_valid) acc <= (s2_first ? bias_ext : acc) + s2_sum;
      end
   end

   // ReLU clamp (no sat), then clip to the output range (sets sat).
   always_comb begin
      relu_v = acc;
      if ((RELU != 0) && (SIGNED != 0) && (acc < 0)) relu_v = '0;
      res_c = relu_v[OUT_W-1:0];
      sat_c = 1'b0;
      if (SIGNED != 0) begin
         if (relu_v > S_MAX) begin
            res_c = S_MAX[OUT_W-1:0];
            sat_c = 1'b1;
         end else if (relu_v < S_MIN) begin
            res_c = S_MIN[OUT_W-1:0];
            sat_c = 1'b1;
         end
      end else if (relu_v > U_MAX) begin
         res_c = U_MAX[OUT_W-1:0];
         sat_c = 1'b1;
      end
   end

   // Output register: clr keeps a held result but drops anything still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         sat       <= 1'b0;
      end else if (clr) begin
         out_valid <= out_valid & ~out_ready;
      end else if (adv) begin
         out_valid <= s3_valid & s3_last;
         if (s3_valid && s3_last) begin
            result <= res_c;
            sat    <= sat_c;
         end
      end
   end

endmodule

// File: tb/tb_conv_channel_accum.sv
// Bench for conv_channel_accum: four instances (unsigned CH=4, signed+ReLU,
// signed without ReLU, unsigned CH=1) share one input stream and out_ready.
module tb_conv_channel_accum;

   localparam int NI = 4;
   localparam bit CFG_SG [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
   localparam bit CFG_RL [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
   localparam int CFG_CH [NI] = '{4, 4, 4, 1};

   typedef struct packed { logic [7:0] r; logic s; } exp_t;
   typedef struct { logic [3:0] d; logic [3:0] wv; logic [7:0] b; exp_t e0, e1, e2; } vec_t;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, out_ready;
   logic [35:0] data2conv, w;
   logic [7:0]  bias;
   logic        ir [NI];
   logic        ov [NI];
   logic        st [NI];
   logic [7:0]  res [NI];
   logic [1:0]  cidx [3];
   logic        cidx3;

   int   checks = 0, failures = 0;
   int   m_acc [NI], m_cnt [NI], pops [NI];
   exp_t exp_q [NI][$];
   bit   held [NI];
   exp_t held_v [NI];
   bit   use_table = 1'b0;
   vec_t tbl [9];

   always #5 clk = ~clk;

   conv_channel_accum #(.SIGNED(0), .RELU(1), .CH(4)) u_uns (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[0]),
      .data2conv(data2conv), .w(w), .bias(bias), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res[0]), .sat(st[0]), .ch_idx(cidx[0]));
   conv_channel_accum #(.SIGNED(1), .RELU(1), .CH(4)) u_sgn (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[1]),
      .data2conv(data2conv), .w(w), .bias(bias), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res[1]), .sat(st[1]), .ch_idx(cidx[1]));
   conv_channel_accum #(.SIGNED(1), .RELU(0), .CH(4)) u_sgn_nr (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[2]),
      .data2conv(data2conv), .w(w), .bias(bias), .out_valid(ov[2]), .out_ready(out_ready),
      .result(res[2]), .sat(st[2]), .ch_idx(cidx[2]));
   conv_channel_accum #(.SIGNED(0), .RELU(1), .CH(1)) u_ch1 (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir[3]),
      .data2conv(data2conv), .w(w), .bias(bias), .out_valid(ov[3]), .out_ready(out_ready),
      .result(res[3]), .sat(st[3]), .ch_idx(cidx3));

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ----------------
   function automatic int ival(input logic [31:0] x, input int bits, input bit sg);
      int v = int'(x);
      if (sg && x[bits-1]) v = v - (1 << bits);
      return v;
   endfunction

   function automatic int dot(input logic [35:0] d, input logic [35:0] wt, input bit sg);
      int s = 0;
      for (int k = 0; k < 9; k++)
         s += ival(32'(d[k*4 +: 4]), 4, sg) * ival(32'(wt[k*4 +: 4]), 4, sg);
      return s;
   endfunction

   function automatic exp_t finish(input int acc, input bit sg, input bit rl);
      exp_t e;
      int   v = acc;
      e.s = 1'b0;
      if (sg) begin
         if (rl && v < 0) v = 0;
         if (v > 127)       begin v = 127;  e.s = 1'b1; end
         else if (v < -128) begin v = -128; e.s = 1'b1; end
      end else if (v > 255) begin
         v = 255; e.s = 1'b1;
      end
      e.r = 8'(v);
      return e;
   endfunction

   task automatic model_beat(input logic [35:0] d, input logic [35:0] wt, input logic [7:0] b);
      for (int i = 0; i < NI; i++) begin
         if (m_cnt[i] == 0) m_acc[i] = ival(32'(b), 8, CFG_SG[i]);
         m_acc[i] += dot(d, wt, CFG_SG[i]);
         m_cnt[i]++;
         if (m_cnt[i] == CFG_CH[i]) begin
            m_cnt[i] = 0;
            if (!(use_table && i < 3)) exp_q[i].push_back(finish(m_acc[i], CFG_SG[i], CFG_RL[i]));
         end
      end
   endtask

   // ---------------- per-cycle observation ----------------
   task automatic sample(input logic ordy);
      for (int i = 0; i < NI; i++) begin
         if (held[i]) begin
            check($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
            check($sformatf("hold_result%0d", i), 32'(res[i]), 32'(held_v[i].r));
            check($sformatf("hold_sat%0d", i), 32'(st[i]), 32'(held_v[i].s));
         end
         check($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(!ov[i] || ordy));
         if (ov[i] === 1'b1 && ordy) begin
            if (exp_q[i].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result%0d actual=%0h required=none", i, res[i]);
            end else begin
               exp_t e = exp_q[i].pop_front();
               check($sformatf("result%0d", i), 32'(res[i]), 32'(e.r));
               check($sformatf("sat%0d", i), 32'(st[i]), 32'(e.s));
               pops[i]++;
            end
         end
         held[i]     = (ov[i] === 1'b1) && !ordy;
         held_v[i].r = res[i];
         held_v[i].s = st[i];
      end
      check("ch_idx0", 32'(cidx[0]), 32'(m_cnt[0]));
      check("ch_idx_ch1", 32'(cidx3), 32'd0);
   endtask

   // One clock cycle, entered and left at a falling edge. A beat is offered only
   // when every instance is ready, so all instances see the same accepted stream.
   task automatic step(input logic iv, input logic [35:0] d, input logic [35:0] wt,
                       input logic [7:0] b, input logic ordy, output bit accepted);
      out_ready = ordy;
      #1;
      accepted  = iv && ir[0] && ir[1] && ir[2] && ir[3];
      in_valid  = accepted;
      data2conv = d;
      w         = wt;
      bias      = b;
      #1;
      sample(ordy);
      if (accepted && !clr && !rst) model_beat(d, wt, b);
      if (clr || rst) for (int i = 0; i < NI; i++) m_cnt[i] = 0;
      @(negedge clk);
   endtask

   task automatic send(input logic [35:0] d, input logic [35:0] wt, input logic [7:0] b);
      bit a = 1'b0;
      int tries = 0;
      while (!a && tries < 50) begin
         step(1'b1, d, wt, b, 1'b1, a);
         tries++;
      end
      if (!a) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted");
      end
   endtask

   task automatic drain();
      bit a;
      int k = 0;
      while (k < 100 && (k < 6 || (exp_q[0].size() + exp_q[1].size() +
                                   exp_q[2].size() + exp_q[3].size()) > 0)) begin
         step(1'b0, '0, '0, '0, 1'b1, a);
         k++;
      end
      if (k == 100) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=pending required=empty");
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("%s_out_valid%0d", tag, i), 32'(ov[i]), 32'd0);
         check($sformatf("%s_result%0d", tag, i), 32'(res[i]), 32'd0);
         check($sformatf("%s_sat%0d", tag, i), 32'(st[i]), 32'd0);
         check($sformatf("%s_in_ready%0d", tag, i), 32'(ir[i]), 32'd1);
      end
      check($sformatf("%s_ch_idx", tag), 32'(cidx[0]), 32'd0);
   endtask

   function automatic vec_t mk(input logic [3:0] d, input logic [3:0] wv, input logic [7:0] b,
                               input logic [7:0] r0, input bit s0, input logic [7:0] r1,
                               input bit s1, input logic [7:0] r2, input bit s2);
      vec_t v;
      v.d = d; v.wv = wv; v.b = b;
      v.e0.r = r0; v.e0.s = s0;
      v.e1.r = r1; v.e1.s = s1;
      v.e2.r = r2; v.e2.s = s2;
      return v;
   endfunction

   initial begin
      bit          a;
      int          p0, sent, stall;
      bit          ordy;
      logic [35:0] ones;
      ones = {9{4'h1}};

      // uniform taps d, weights wv, bias b -> {unsigned, signed+relu, signed} expectations
      tbl[0] = mk(4'h1, 4'h1, 8'h00, 8'd36,  1'b0, 8'd36,  1'b0, 8'd36,  1'b0);
      tbl[1] = mk(4'hF, 4'hF, 8'h00, 8'd255, 1'b1, 8'd36,  1'b0, 8'd36,  1'b0);
      tbl[2] = mk(4'hF, 4'h1, 8'h00, 8'd255, 1'b1, 8'd0,   1'b0, 8'hDC,  1'b0);
      tbl[3] = mk(4'h1, 4'h1, 8'hF6, 8'd255, 1'b1, 8'd26,  1'b0, 8'd26,  1'b0);
      tbl[4] = mk(4'h7, 4'h7, 8'h7F, 8'd255, 1'b1, 8'd127, 1'b1, 8'd127, 1'b1);
      tbl[5] = mk(4'h8, 4'h7, 8'h80, 8'd255, 1'b1, 8'd0,   1'b0, 8'h80,  1'b1);
      tbl[6] = mk(4'h0, 4'h9, 8'h05, 8'd5,   1'b0, 8'd5,   1'b0, 8'd5,   1'b0);
      tbl[7] = mk(4'h2, 4'h3, 8'h10, 8'd232, 1'b0, 8'd127, 1'b1, 8'd127, 1'b1);
      tbl[8] = mk(4'h1, 4'hF, 8'h30, 8'd255, 1'b1, 8'd12,  1'b0, 8'd12,  1'b0);

      for (int i = 0; i < NI; i++) begin m_acc[i] = 0; m_cnt[i] = 0; pops[i] = 0; held[i] = 1'b0; end
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      data2conv = '0; w = '0; bias = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Group of ones: 36, and out_valid exactly three edges after the last beat.
      use_table = 1'b1;
      exp_q[0].push_back(tbl[0].e0); exp_q[1].push_back(tbl[0].e1); exp_q[2].push_back(tbl[0].e2);
      repeat (4) send(ones, ones, 8'h00);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("latency_k%0d", k), 32'(ov[0]), 32'(k == 3));
         if (k < 3) step(1'b0, '0, '0, '0, 1'b0, a);
      end

      // Table of uniform-operand groups, back to back.
      for (int t = 0; t < 9; t++) begin
         exp_q[0].push_back(tbl[t].e0); exp_q[1].push_back(tbl[t].e1); exp_q[2].push_back(tbl[t].e2);
         repeat (4) send({9{tbl[t].d}}, {9{tbl[t].wv}}, tbl[t].b);
      end
      drain();
      use_table = 1'b0;

      // 12 beats, first result held five cycles: nothing lost, order kept.
      p0 = pops[0]; sent = 0; stall = -1;
      for (int cyc = 0; cyc < 200 && (sent < 12 || exp_q[0].size() > 0); cyc++) begin
         if (stall < 0 && ov[0] === 1'b1) stall = 5;
         ordy = !(stall > 0);
         step(sent < 12, ones, ones, 8'h00, ordy, a);
         if (a) sent++;
         if (stall > 0) begin
            check("stall_in_ready", 32'(ir[0]), 32'd0);
            stall--;
         end
      end
      check("stall_result_count", 32'(pops[0] - p0), 32'd3);
      drain();

      // clr mid-group (with a discarded beat), then rst mid-group.
      for (int pass = 0; pass < 2; pass++) begin
         p0 = pops[0];
         repeat (2) send(ones, ones, 8'h00);
         repeat (4) step(1'b0, '0, '0, '0, 1'b1, a);
         check("mid_group_ch_idx", 32'(cidx[0]), 32'd2);
         if (pass == 0) clr = 1'b1; else rst = 1'b1;
         step(1'b1, {9{4'hF}}, {9{4'hF}}, 8'hFF, 1'b1, a);
         clr = 1'b0; rst = 1'b0;
         if (pass == 1) check_reset_state("mid_rst");
         check("flush_ch_idx", 32'(cidx[0]), 32'd0);
         repeat (4) send(ones, ones, 8'h00);
         drain();
         check($sformatf("flush_result_count%0d", pass), 32'(pops[0] - p0), 32'd1);
      end

      // CH=1: four beats give four results on four consecutive cycles.
      repeat (4) send(ones, ones, 8'h00);
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("ch1_stream_k%0d", k), 32'(ov[3]), 32'(k < 4));
         step(1'b0, '0, '0, '0, 1'b1, a);
      end
      drain();

      // Random traffic against the model with random back-pressure.
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 3) != 0, 36'({$urandom(), $urandom()}),
              36'({$urandom(), $urandom()}), 8'($urandom()), $urandom_range(0, 9) < 7, a);
      drain();
      for (int i = 0; i < NI; i++)
         check($sformatf("queue_empty%0d", i), 32'(exp_q[i].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
